// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } state_e;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with single-cycle flush; head data is the oldest entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is only meaningful while count_o > 0.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: sequential PC requests, in-order responses buffered for decode,
// redirect flushes the queue and drops wrong-path responses still in flight.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned   N        = 64,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [N-1:0]        imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [N-1:0]        redirect_pc,
  output logic                instr_valid_D,
  input  logic                instr_ready_D,
  output logic [INSTR_W-1:0]  instr_D,
  output logic [N-1:0]        pc_D
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = N + INSTR_W;
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic [N-1:0]  fetch_pc_q, fetch_pc_d;
  logic [N-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] fifo_count;
  logic [EW-1:0] fifo_head;
  logic [CW:0]   credit_used;
  logic          req_fire, push, pop;

  // Buffered plus in-flight entries may never exceed the queue size.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_valid = (state_q == FETCH) && (credit_used < DEPTH_LIM);
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response landing in the redirect cycle is wrong-path and is dropped.
  assign push          = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign instr_valid_D = (fifo_count != '0);
  assign pop           = instr_valid_D && instr_ready_D && !redirect_valid;
  assign instr_D       = instr_valid_D ? fifo_head[INSTR_W-1:0] : '0;
  assign pc_D          = instr_valid_D ? fifo_head[EW-1:INSTR_W] : '0;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .data_i  ({rsp_pc_q, imem_rsp_data}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Next-state: PC/counter updates, then redirect overrides everything.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

    if (req_fire) fetch_pc_d = fetch_pc_q + N'(PC_STEP);
    if (push)     rsp_pc_d   = rsp_pc_q + N'(PC_STEP);
    if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      // Everything still in flight after this cycle is wrong-path.
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != '0) ? FLUSH : FETCH;
    end else begin
      unique case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   state_d = FETCH;
        FLUSH:   if (drop_cnt_d == '0) state_d = FETCH;
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue with an in-order variable-latency memory and a
// queue-based reference model compared every cycle on the falling edge.
module tb_fetch_queue;

  localparam int unsigned N     = 64;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [N-1:0]  imem_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [31:0]   imem_rsp_data = '0;
  logic          redirect_valid = 1'b0;
  logic [N-1:0]  redirect_pc = '0;
  logic          instr_valid_D;
  logic          instr_ready_D = 1'b0;
  logic [31:0]   instr_D;
  logic [N-1:0]  pc_D;

  always #5 clk = ~clk;

  fetch_queue #(
    .N        (N),
    .DEPTH    (DEPTH),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid_D  (instr_valid_D),
    .instr_ready_D  (instr_ready_D),
    .instr_D        (instr_D),
    .pc_D           (pc_D)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  ent_t        m_q[$];
  bit          m_run;
  bit          m_flush;
  logic [63:0] m_fetch_pc;
  int          m_inflight;
  int          m_drop;

  // Memory model and logs
  mreq_t       mem_q[$];
  logic [63:0] req_log[$];
  logic [63:0] pop_log[$];
  int          pop_cyc[$];

  // Stimulus knobs
  int          p_ready, p_rsp, p_dready, p_redir, lat_lo, lat_hi, max_req;
  bit          rsp_en;
  bit          redir_once = 1'b0;
  logic [63:0] redir_target;

  bit          e_req, e_iv, fire, pop;
  logic [63:0] e_pc;
  logic [31:0] e_in;

  function automatic logic [31:0] hash(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [63:0] rand_pc();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(3) == 0) v = 64'hFFFF_FFFF_FFFF_FFF0 | (v & 64'hC);
    return v & ~64'h3;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] log_at(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // Reference model and per-cycle comparison, away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      m_q.delete();
      mem_q.delete();
      m_run      = 1'b0;
      m_flush    = 1'b0;
      m_fetch_pc = 64'h0;
      m_inflight = 0;
      m_drop     = 0;
      check64("rst_req_valid", imem_req_valid, 0);
      check64("rst_instr_valid", instr_valid_D, 0);
      check64("rst_pc_D", pc_D, 0);
      check64("rst_instr_D", instr_D, 0);
      check64("rst_addr", imem_addr, 0);
    end else begin
      e_req = m_run && !m_flush && (m_q.size() + m_inflight < DEPTH);
      e_iv  = m_q.size() > 0;
      e_pc  = 64'h0;
      e_in  = 32'h0;
      if (e_iv) begin
        e_pc = m_q[0].pc;
        e_in = m_q[0].data;
      end
      check64("req_valid", imem_req_valid, e_req);
      check64("imem_addr", imem_addr, m_fetch_pc);
      check64("instr_valid", instr_valid_D, e_iv);
      check64("pc_D", pc_D, e_pc);
      check64("instr_D", instr_D, e_in);

      fire = imem_req_valid && imem_req_ready;
      pop  = e_iv && instr_ready_D && !redirect_valid;
      if (pop) begin
        pop_log.push_back(m_q[0].pc);
        pop_cyc.push_back(cyc);
        void'(m_q.pop_front());
      end
      if (imem_rsp_valid && mem_q.size() > 0) begin
        m_inflight--;
        if (m_drop > 0) m_drop--;
        else if (!redirect_valid) m_q.push_back('{pc: mem_q[0].addr, data: imem_rsp_data});
        void'(mem_q.pop_front());
      end
      if (fire) begin
        req_log.push_back(m_fetch_pc);
        mem_q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
        m_fetch_pc = m_fetch_pc + 64'd4;
        m_inflight++;
      end
      if (redirect_valid) begin
        m_q.delete();
        m_fetch_pc = redirect_pc;
        m_drop     = m_inflight;
        m_flush    = m_drop > 0;
      end else if (m_drop == 0) begin
        m_flush = 1'b0;
      end
      m_run = 1'b1;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    imem_req_ready = (int'($urandom_range(99)) < p_ready) && (req_log.size() < max_req);
    instr_ready_D  = int'($urandom_range(99)) < p_dready;
    if (redir_once) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_target;
      redir_once     = 1'b0;
    end else begin
      redirect_valid = int'($urandom_range(99)) < p_redir;
      redirect_pc    = rand_pc();
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (reset && rsp_en && mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc && int'($urandom_range(99)) < p_rsp) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = hash(mem_q[0].addr);
      end
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready_D  = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    redir_once     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_log.delete();
    pop_log.delete();
    pop_cyc.delete();
    reset = 1'b1;
  endtask

  task automatic set_knobs(input int rdy, input int rsp, input int drdy, input int redir,
                           input int llo, input int lhi);
    p_ready  = rdy;
    p_rsp    = rsp;
    p_dready = drdy;
    p_redir  = redir;
    lat_lo   = llo;
    lat_hi   = lhi;
    max_req  = 1 << 30;
    rsp_en   = 1'b1;
  endtask

  // Three requests at 0x10..0x18 held in flight, then redirect to 0x100 (one more
  // request handshakes in the redirect cycle).
  task automatic setup_flush();
    do_reset();
    set_knobs(100, 100, 100, 0, 1, 1);
    rsp_en  = 1'b0;
    max_req = 0;
    repeat (2) step();
    redir_target = 64'h10;
    redir_once   = 1'b1;
    step();
    max_req = 3;
    repeat (6) step();
    check64("pre_req_cnt", req_log.size(), 3);
    for (int i = 0; i < 3; i++) check64("pre_req_addr", log_at(req_log, i), 64'h10 + 4 * i);
    max_req      = 1 << 30;
    redir_target = 64'h100;
    redir_once   = 1'b1;
    step();
  endtask

  initial begin
    set_knobs(0, 0, 0, 0, 1, 1);

    // Sequential fetch, 1-cycle memory, decode always ready.
    do_reset();
    set_knobs(100, 100, 100, 0, 1, 1);
    repeat (20) step();
    for (int i = 0; i < 4; i++) begin
      check64("seq_req", log_at(req_log, i), 64'h4 * i);
      check64("seq_pop", log_at(pop_log, i), 64'h4 * i);
    end
    check64("seq_back_to_back", (pop_cyc.size() > 3) ? pop_cyc[3] - pop_cyc[0] : -1, 3);

    // Decode stalled: credits cap requests at DEPTH.
    do_reset();
    set_knobs(100, 100, 0, 0, 1, 1);
    repeat (12) step();
    check64("stall_req_cnt", req_log.size(), 4);
    check64("stall_last_req", log_at(req_log, 3), 64'hC);
    check64("stall_req_valid", imem_req_valid, 0);
    check64("stall_head_pc", pc_D, 64'h0);
    check64("stall_head_instr", instr_D, hash(64'h0));
    p_dready = 100;
    repeat (12) step();
    for (int i = 0; i < 4; i++) check64("drain_pop", log_at(pop_log, i), 64'h4 * i);
    check64("resume_req", log_at(req_log, 4), 64'h10);

    // Redirect with wrong-path requests in flight.
    setup_flush();
    repeat (3) begin
      step();
      check64("flush_req_valid", imem_req_valid, 0);
    end
    rsp_en = 1'b1;
    repeat (15) step();
    check64("redir_first_req", log_at(req_log, 4), 64'h100);
    check64("redir_first_pop", log_at(pop_log, 0), 64'h100);

    // Asynchronous reset in the middle of a flush.
    setup_flush();
    step();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check64("areset_req_valid", imem_req_valid, 0);
    check64("areset_addr", imem_addr, 0);
    check64("areset_instr_valid", instr_valid_D, 0);
    check64("areset_pc_D", pc_D, 0);
    check64("areset_instr_D", instr_D, 0);
    do_reset();
    set_knobs(100, 100, 100, 0, 1, 1);
    repeat (6) step();
    check64("areset_first_req", log_at(req_log, 0), 64'h0);

    // Randomised traffic with redirects, back-pressure and variable latency.
    do_reset();
    set_knobs(70, 60, 60, 4, 1, 4);
    repeat (3000) step();
    set_knobs(90, 90, 20, 10, 1, 2);
    repeat (2000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
